load_channel_arbiter: RTL and testbench
=======================================

LOAD_CHANNEL_ARBITER -- requirements
Module: load_channel_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 8, words per cache block refill; power of two, 2..16.
REQ-002 Parameter OFFSET, default $clog2(BLOCK_WORDS), word-select bits within a block.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 request_i  input  2  per-port block refill request, level, held until grant; port 0 = instruction cache, port 1 = data cache.
REQ-006 address_i  input  2x32  per-port miss address; bits [OFFSET+1:2] select the critical word.
REQ-007 grant_o  output  2  one-cycle pulse accepting the port's request.
REQ-008 valid_o  output  2  per-port returned-word strobe.
REQ-009 data_o  output  32  returned word, shared by both ports, qualified by valid_o.
REQ-010 index_o  output  OFFSET  block word index of data_o.
REQ-011 done_o  output  2  per-port pulse coincident with the last word of the burst.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 load_request_o  output  1  one-cycle word read request to memory.
REQ-014 load_address_o  output  32  word-aligned read address, bits [1:0] = 0.
REQ-015 load_data_i  input  32  memory read data.
REQ-016 load_valid_i  input  1  memory data strobe, one per load_request_o.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when any request_i bit is set.
- ISSUE -> WAIT unconditionally.
- WAIT -> ISSUE on load_valid_i with beats remaining.
- WAIT -> IDLE on load_valid_i of the last beat.
REQ-018 Arbitration in IDLE: a lone requester wins; on a tie the port not granted last wins (round-robin).
REQ-019 On acceptance, latch the winner id, the block base address, and start word s = address_i[OFFSET+1:2]; clear beat counter c.
REQ-020 grant_o[winner] is high only in the first ISSUE cycle of a burst; request_i is ignored outside IDLE.
REQ-021 In ISSUE, load_request_o=1 and load_address_o = {base[31:OFFSET+2], (s+c) mod BLOCK_WORDS, 2'b00}: critical word first, wrapping inside the block.
REQ-022 Only one memory read is outstanding at a time.
REQ-023 In WAIT with load_valid_i, same cycle (combinational):
- valid_o[winner]=1, data_o=load_data_i, index_o=(s+c) mod BLOCK_WORDS;
- done_o[winner]=1 when c=BLOCK_WORDS-1.
REQ-024 On the last beat, last-granted <= winner. The earliest next acceptance is the cycle after returning to IDLE.
REQ-025 Timing: a request sampled in IDLE at cycle T gives grant_o and the first load_request_o at T+1. With zero-wait memory (load_valid_i at T+2), the minimum is 2 cycles/beat, and the last word arrives at T+2*BLOCK_WORDS.
REQ-026 load_valid_i outside WAIT is ignored; no output changes.
REQ-027 Outside WAIT-with-valid, valid_o=0, done_o=0, data_o=0, index_o=0.
REQ-028 A burst is never aborted by the requester; it always completes BLOCK_WORDS beats.

Reset
REQ-029 rst_i returns the FSM to IDLE from any state, including mid-burst; the burst in flight is discarded and no done_o is issued.
REQ-030 Reset values:
- grant_o, valid_o, done_o = 0; busy_o = 0; load_request_o = 0;
- load_address_o, data_o, index_o = 0;
- c = 0; last-granted = port 1, so port 0 wins the first tie.

Structure
REQ-031 Shared package load_arbiter_pkg: FSM state enum, port constants (ICACHE_PORT=0, DCACHE_PORT=1), number of ports.
REQ-032 Arbitration lives in sub-module round_robin_arbiter (request vector, last-granted in, one-hot grant out, combinational).
REQ-033 The FSM, counter and address generation stay in load_channel_arbiter; no FIFOs.

Verification
REQ-034 Port 0 alone, address_i[0]=0x0000_1014, BLOCK_WORDS=8, zero-wait memory -> grant_o[0] at T+1; load_address_o sequence 0x1014,0x1018,0x101C,0x1000..0x1010; index_o 5,6,7,0..4; done_o[0] with index 4 at T+16.
REQ-035 Both ports request in the same cycle after reset -> port 0 is served first; port 1 is granted the cycle after port 0's IDLE return; simultaneous re-request then grants port 1 then port 0 alternately.
REQ-036 Memory with a 3-cycle valid delay -> exactly one load_request_o per beat, never a second before load_valid_i; 8 beats complete.
REQ-037 rst_i asserted in WAIT at beat 3 of port 1 -> next cycle IDLE, busy_o=0, no done_o; a pending port 0 request is granted on the first cycle after reset is released.
REQ-038 Spurious load_valid_i in IDLE and in ISSUE -> valid_o stays 0 and the beat counter is unchanged.

Source files
------------

// File: rtl/load_arbiter_pkg.sv
// Shared definitions for the two-port block-refill load channel.
package load_arbiter_pkg;

  localparam int unsigned NUM_PORTS   = 2;
  localparam int unsigned ICACHE_PORT = 0;
  localparam int unsigned DCACHE_PORT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/round_robin_arbiter.sv
// Two-port round-robin picker: a lone requester wins, a tie goes to the
// port that was not granted last.
module round_robin_arbiter
  import load_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] request_i,
  input  logic                 last_i,
  output logic [NUM_PORTS-1:0] grant_o
);

  // One-hot grant from the request vector and last-granted port
  always_comb begin
    grant_o = '0;
    if (request_i[ICACHE_PORT] && request_i[DCACHE_PORT]) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = request_i;
    end
  end

endmodule

// File: rtl/load_channel_arbiter.sv
// Shares one word-wide memory read channel between the instruction and data
// caches, fetching a whole block critical-word-first, one read at a time.
module load_channel_arbiter
  import load_arbiter_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned OFFSET      = $clog2(BLOCK_WORDS)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_PORTS-1:0]        request_i,
  input  logic [NUM_PORTS-1:0][31:0]  address_i,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic [NUM_PORTS-1:0]        valid_o,
  output logic [31:0]                 data_o,
  output logic [OFFSET-1:0]           index_o,
  output logic [NUM_PORTS-1:0]        done_o,
  output logic                        busy_o,
  output logic                        load_request_o,
  output logic [31:0]                 load_address_o,
  input  logic [31:0]                 load_data_i,
  input  logic                        load_valid_i
);

  state_e                state_q, state_d;
  logic                  winner_q, winner_d;
  logic                  last_q, last_d;
  logic [OFFSET-1:0]     s_q, s_d;
  logic [OFFSET-1:0]     c_q, c_d;
  logic [29-OFFSET:0]    base_q, base_d;
  logic [NUM_PORTS-1:0]  grant_q, grant_d;
  logic                  load_req_q, load_req_d;
  logic [31:0]           load_addr_q, load_addr_d;

  logic [NUM_PORTS-1:0]  arb_grant;
  logic [31:0]           sel_addr;
  logic [OFFSET-1:0]     word_idx;
  logic [OFFSET-1:0]     word_next;
  logic                  beat;
  logic                  last_beat;
  logic                  addr_lsb_unused;

  round_robin_arbiter u_arb (
    .request_i (request_i),
    .last_i    (last_q),
    .grant_o   (arb_grant)
  );

  assign sel_addr        = address_i[arb_grant[DCACHE_PORT]];
  assign addr_lsb_unused = ^sel_addr[1:0];
  // Word position wraps naturally inside the block through OFFSET-bit arithmetic
  assign word_idx        = s_q + c_q;
  assign word_next       = word_idx + 1'b1;
  assign beat            = (state_q == ST_WAIT) && load_valid_i;
  assign last_beat       = beat && (c_q == OFFSET'(BLOCK_WORDS - 1));

  // Next-state, burst bookkeeping and registered memory request
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_d      = last_q;
    s_d         = s_q;
    c_d         = c_q;
    base_d      = base_q;
    grant_d     = '0;
    load_req_d  = 1'b0;
    load_addr_d = load_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (|request_i) begin
          state_d     = ST_ISSUE;
          winner_d    = arb_grant[DCACHE_PORT];
          base_d      = sel_addr[31:OFFSET+2];
          s_d         = sel_addr[OFFSET+1:2];
          c_d         = '0;
          grant_d     = arb_grant;
          load_req_d  = 1'b1;
          load_addr_d = {sel_addr[31:2], 2'b00};
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (load_valid_i) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            last_d  = winner_q;
            c_d     = '0;
          end else begin
            state_d     = ST_ISSUE;
            c_d         = c_q + 1'b1;
            load_req_d  = 1'b1;
            load_addr_d = {base_q, word_next, 2'b00};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any burst in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      winner_q    <= 1'b0;
      last_q      <= 1'(DCACHE_PORT);
      s_q         <= '0;
      c_q         <= '0;
      base_q      <= '0;
      grant_q     <= '0;
      load_req_q  <= 1'b0;
      load_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      s_q         <= s_d;
      c_q         <= c_d;
      base_q      <= base_d;
      grant_q     <= grant_d;
      load_req_q  <= load_req_d;
      load_addr_q <= load_addr_d;
    end
  end

  // Returned-word path passes memory data straight through to the winner
  always_comb begin
    valid_o = '0;
    done_o  = '0;
    data_o  = '0;
    index_o = '0;
    if (beat) begin
      valid_o[winner_q] = 1'b1;
      data_o            = load_data_i;
      index_o           = word_idx;
      if (last_beat) begin
        done_o[winner_q] = 1'b1;
      end
    end
  end

  assign grant_o        = grant_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign load_request_o = load_req_q;
  assign load_address_o = load_addr_q;

endmodule

// File: tb/tb_load_channel_arbiter.sv
// Directed and randomized bench for load_channel_arbiter with a
// transaction-level reference model of arbitration and burst ordering.
module tb_load_channel_arbiter;

  localparam int BW  = 8;
  localparam int OFF = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       request;
  logic [1:0][31:0] address;
  logic [1:0]       grant;
  logic [1:0]       valid;
  logic [31:0]      data;
  logic [OFF-1:0]   index;
  logic [1:0]       done;
  logic             busy;
  logic             load_req;
  logic [31:0]      load_addr;
  logic [31:0]      load_data;
  logic             load_valid;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned cycle  = 0;
  int          last_port = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  load_channel_arbiter #(.BLOCK_WORDS(BW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .request_i      (request),
    .address_i      (address),
    .grant_o        (grant),
    .valid_o        (valid),
    .data_o         (data),
    .index_o        (index),
    .done_o         (done),
    .busy_o         (busy),
    .load_request_o (load_req),
    .load_address_o (load_addr),
    .load_data_i    (load_data),
    .load_valid_i   (load_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: who wins arbitration given requests and last-served port
  function automatic int pick(input logic [1:0] req, input int last);
    if (req == 2'b11) return (last == 0) ? 1 : 0;
    return req[1] ? 1 : 0;
  endfunction

  // Reference: word index and address of the k-th beat of a burst
  function automatic logic [31:0] beat_idx(input logic [31:0] a, input int k);
    return ((a >> 2) + 32'(k)) % 32'(BW);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k);
    logic [31:0] blk;
    blk = a & ~(32'(BW) * 4 - 1);
    return blk + (beat_idx(a, k) << 2);
  endfunction

  // Acts as memory for one burst and checks every cycle of it.
  // Called with the FSM in IDLE and the request set up; returns in IDLE.
  task automatic burst(input int port, input logic [31:0] a, input int dmin,
                       input int dmax, input bit noise, input int abort_beat);
    logic [31:0] word;
    int unsigned d;
    int unsigned g_cyc;
    tick();
    g_cyc = cycle;
    chk("grant", 32'(grant), 32'(1) << port);
    request[port] = 1'b0;
    for (int k = 0; k < BW; k++) begin
      if (k > 0) chk("grant_clear", 32'(grant), 0);
      chk("busy", 32'(busy), 1);
      chk("load_req", 32'(load_req), 1);
      chk("load_addr", load_addr, beat_addr(a, k));
      if (noise) begin
        request    = 2'($urandom);
        address[0] = $urandom;
        address[1] = $urandom;
        load_valid = 1'($urandom_range(0, 1));
        load_data  = $urandom;
        #1;
        chk("valid_in_issue", 32'(valid), 0);
      end
      tick();
      load_valid = 1'b0;
      d = $urandom_range(dmin, dmax);
      for (int j = 0; j < int'(d); j++) begin
        #1;
        chk("no_extra_req", 32'(load_req), 0);
        chk("valid_wait", 32'(valid), 0);
        tick();
      end
      if (k == abort_beat) begin
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_req", 32'(load_req), 0);
        chk("abort_grant", 32'(grant), 0);
        rst = 1'b0;
        return;
      end
      word       = $urandom;
      load_data  = word;
      load_valid = 1'b1;
      #1;
      chk("load_req_wait", 32'(load_req), 0);
      chk("valid", 32'(valid), 32'(1) << port);
      chk("data", data, word);
      chk("index", 32'(index), beat_idx(a, k));
      chk("done", 32'(done), (k == BW - 1) ? (32'(1) << port) : 32'(0));
      if (k == BW - 1 && dmax == 0) chk("burst_len", cycle - g_cyc, 15);
      tick();
      load_valid = 1'b0;
    end
    #1;
    chk("busy_idle", 32'(busy), 0);
    chk("valid_idle", 32'(valid), 0);
    chk("done_idle", 32'(done), 0);
    last_port = port;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    rst        = 1'b1;
    request    = '0;
    address    = '0;
    load_valid = 1'b0;
    load_data  = '0;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load_req", 32'(load_req), 0);
    chk("rst_load_addr", load_addr, 0);
    chk("rst_data", data, 0);
    chk("rst_index", 32'(index), 0);
    rst = 1'b0;

    // Spurious memory strobes while idle
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_data = $urandom;
      #1;
      chk("idle_spur_valid", 32'(valid), 0);
      chk("idle_spur_data", data, 0);
      chk("idle_spur_busy", 32'(busy), 0);
      tick();
    end
    load_valid = 1'b0;

    // Port 0 alone, critical word 5 of block 0x1000, zero-wait memory
    request    = 2'b01;
    address[0] = 32'h0000_1014;
    burst(0, 32'h0000_1014, 0, 0, 1'b0, -1);

    // Simultaneous requests alternate between the ports
    for (int i = 0; i < 4; i++) begin
      request    = 2'b11;
      address[0] = $urandom;
      address[1] = $urandom;
      p = pick(request, last_port);
      burst(p, address[p], 0, 0, 1'b0, -1);
    end

    // Slow memory: three-cycle return latency on every beat
    request    = 2'b01;
    address[0] = $urandom;
    burst(0, address[0], 3, 3, 1'b0, -1);

    // Reset during port 1's fourth beat, port 0 left pending
    request    = 2'b11;
    address[0] = $urandom;
    address[1] = $urandom;
    p = pick(request, last_port);
    burst(p, address[p], 0, 0, 1'b0, 3);
    address[0] = $urandom;
    burst(pick(request, last_port), address[0], 0, 1, 1'b0, -1);

    // Random traffic with request/address churn and spurious strobes
    for (int i = 0; i < 12; i++) begin
      request    = 2'($urandom_range(1, 3));
      address[0] = $urandom;
      address[1] = $urandom;
      p = pick(request, last_port);
      burst(p, address[p], 0, 2, 1'b1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
